ctrl_code_gen_stage: RTL and testbench

Parametrised stage-4 control-code generator for the pipelined processor. It registers the decoded memory, stack and writeback strobes for the instruction leaving the opcode buffer, and qualifies them with the selected condition flag. It adds stall, flush and reset handling to the stage. When the address is wider than the data word, it runs a multi-beat sequence so that call and return push or pop the full return address one byte per cycle.

---
 rtl/ctrl_code_gen_stage.sv | 164 ++++++++++++++++
 tb/tb_ctrl_code_gen_stage.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/ctrl_code_gen_stage.sv
// Stage-4 control-code generator: registers decoded memory/stack/writeback
// strobes, qualifies them with the condition flag and sequences multi-byte pushes/pops.
module ctrl_code_gen_stage #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  localparam int BEATS = ADDR_W / DATA_W,
  localparam int BS_W  = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [7:0]      opcode,
  input  logic            fl,
  input  logic            wr_in,
  input  logic            lrn_in,
  input  logic            lr0_in,
  input  logic            ern_in,
  input  logic            isp_in,
  output logic            out_valid,
  output logic            wr,
  output logic            lrn,
  output logic            lr0,
  output logic            ern,
  output logic            lsp,
  output logic            dsp,
  output logic            isp,
  output logic            lop,
  output logic [BS_W-1:0] byte_sel,
  output logic            squash,
  output logic            busy
);

  typedef enum logic {IDLE, BEAT} state_t;

  localparam logic [BS_W-1:0] LAST = BS_W'(BEATS - 1);

  state_t          state_q, state_d;
  logic [BS_W-1:0] cnt_q, cnt_d;
  logic [BS_W-1:0] bsel_q, bsel_d;
  logic            ov_q, ov_d;
  logic            wr_q, wr_d, lrn_q, lrn_d, lr0_q, lr0_d, ern_q, ern_d;
  logic            lsp_q, lsp_d, dsp_q, dsp_d, isp_q, isp_d, lop_q, lop_d;
  logic            sq_q, sq_d;

  logic lsp_dec, dsp_dec, efl_dec, lop_dec, addr_cls, fail;

  always_comb begin
    lsp_dec = 1'b0;
    dsp_dec = 1'b0;
    efl_dec = 1'b0;
    lop_dec = 1'b0;
    casez (opcode)
      8'b0001_0000:                           lsp_dec = 1'b1;
      8'b0000_0101, 8'b0000_0110,
      8'b0110_1???:                           dsp_dec = 1'b1;
      8'b0011_????:                           begin dsp_dec = 1'b1; efl_dec = 1'b1; end
      8'b0000_1???, 8'b0010_1???,
      8'b0100_1???:                           efl_dec = 1'b1;
      8'b1111_1???:                           lop_dec = 1'b1;
      default:                                ;
    endcase
  end

  // CUD, CUA, RTU, CCD, CCA, RTC move a full return address through the stack
  assign addr_cls = (opcode == 8'b0000_0101) || (opcode == 8'b0000_0110) ||
                    (opcode == 8'b0000_0111) || (opcode[7:4] == 4'b0011) ||
                    (opcode[7:3] == 5'b0100_1);
  assign fail = efl_dec & ~fl;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bsel_d  = bsel_q;
    ov_d    = ov_q;
    wr_d    = wr_q;
    lrn_d   = lrn_q;
    lr0_d   = lr0_q;
    ern_d   = ern_q;
    lsp_d   = lsp_q;
    dsp_d   = dsp_q;
    isp_d   = isp_q;
    lop_d   = lop_q;
    sq_d    = sq_q;
    if (!stall) begin
      if (state_q == BEAT) begin
        // later beats re-emit only the latched wr/dsp/isp strobes
        ov_d   = 1'b1;
        bsel_d = cnt_q;
        lrn_d  = 1'b0;
        lr0_d  = 1'b0;
        ern_d  = 1'b0;
        lsp_d  = 1'b0;
        lop_d  = 1'b0;
        sq_d   = 1'b0;
        cnt_d  = cnt_q + BS_W'(1);
        if (cnt_q == LAST) state_d = IDLE;
      end else begin
        ov_d   = in_valid;
        bsel_d = '0;
        wr_d   = in_valid & wr_in & ~fail;
        lrn_d  = in_valid & lrn_in & ~fail;
        lr0_d  = in_valid & lr0_in & ~fail;
        ern_d  = in_valid & ern_in & ~fail;
        lsp_d  = in_valid & lsp_dec;
        dsp_d  = in_valid & ((isp_in & fail) | (dsp_dec & ~fail));
        isp_d  = in_valid & isp_in & ~fail;
        lop_d  = in_valid & lop_dec;
        sq_d   = in_valid & fail;
        if ((BEATS > 1) && in_valid && addr_cls && !fail) begin
          state_d = BEAT;
          cnt_d   = BS_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bsel_q  <= '0;
      ov_q    <= 1'b0;
      wr_q    <= 1'b0;
      lrn_q   <= 1'b0;
      lr0_q   <= 1'b0;
      ern_q   <= 1'b0;
      lsp_q   <= 1'b0;
      dsp_q   <= 1'b0;
      isp_q   <= 1'b0;
      lop_q   <= 1'b0;
      sq_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bsel_q  <= bsel_d;
      ov_q    <= ov_d;
      wr_q    <= wr_d;
      lrn_q   <= lrn_d;
      lr0_q   <= lr0_d;
      ern_q   <= ern_d;
      lsp_q   <= lsp_d;
      dsp_q   <= dsp_d;
      isp_q   <= isp_d;
      lop_q   <= lop_d;
      sq_q    <= sq_d;
    end
  end

  assign out_valid = ov_q;
  assign wr        = wr_q;
  assign lrn       = lrn_q;
  assign lr0       = lr0_q;
  assign ern       = ern_q;
  assign lsp       = lsp_q;
  assign dsp       = dsp_q;
  assign isp       = isp_q;
  assign lop       = lop_q;
  assign byte_sel  = bsel_q;
  assign squash    = sq_q;
  assign busy      = (state_q == BEAT);

endmodule

// File: tb/tb_ctrl_code_gen_stage.sv
// Directed bench: three instances (1, 2 and 3 beats) share stimulus; each
// check observes the instance relevant to that scenario.
module tb_ctrl_code_gen_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, stall, flush, in_valid, fl;
  logic       wr_in, lrn_in, lr0_in, ern_in, isp_in;
  logic [7:0] opcode;

  logic [2:0] ov, wr, lrn, lr0, ern, lsp, dsp, isp, lop, sq, busy;
  logic [0:0] bsA, bsB;
  logic [1:0] bsC;

  ctrl_code_gen_stage #(.DATA_W(8), .ADDR_W(8)) u_a (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .opcode(opcode), .fl(fl), .wr_in(wr_in), .lrn_in(lrn_in), .lr0_in(lr0_in),
    .ern_in(ern_in), .isp_in(isp_in), .out_valid(ov[0]), .wr(wr[0]), .lrn(lrn[0]),
    .lr0(lr0[0]), .ern(ern[0]), .lsp(lsp[0]), .dsp(dsp[0]), .isp(isp[0]),
    .lop(lop[0]), .byte_sel(bsA), .squash(sq[0]), .busy(busy[0]));

  ctrl_code_gen_stage #(.DATA_W(8), .ADDR_W(16)) u_b (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .opcode(opcode), .fl(fl), .wr_in(wr_in), .lrn_in(lrn_in), .lr0_in(lr0_in),
    .ern_in(ern_in), .isp_in(isp_in), .out_valid(ov[1]), .wr(wr[1]), .lrn(lrn[1]),
    .lr0(lr0[1]), .ern(ern[1]), .lsp(lsp[1]), .dsp(dsp[1]), .isp(isp[1]),
    .lop(lop[1]), .byte_sel(bsB), .squash(sq[1]), .busy(busy[1]));

  ctrl_code_gen_stage #(.DATA_W(8), .ADDR_W(24)) u_c (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
    .opcode(opcode), .fl(fl), .wr_in(wr_in), .lrn_in(lrn_in), .lr0_in(lr0_in),
    .ern_in(ern_in), .isp_in(isp_in), .out_valid(ov[2]), .wr(wr[2]), .lrn(lrn[2]),
    .lr0(lr0[2]), .ern(ern[2]), .lsp(lsp[2]), .dsp(dsp[2]), .isp(isp[2]),
    .lop(lop[2]), .byte_sel(bsC), .squash(sq[2]), .busy(busy[2]));

  int checks = 0;
  int failures = 0;

  // Observation word: {ov, wr, lrn, lr0, ern, lsp, dsp, isp, lop, squash, busy, byte_sel[1:0]}
  function automatic logic [12:0] obs(input int k);
    logic [1:0] bs;
    bs = (k == 0) ? {1'b0, bsA} : (k == 1) ? {1'b0, bsB} : bsC;
    return {ov[k], wr[k], lrn[k], lr0[k], ern[k], lsp[k], dsp[k], isp[k],
            lop[k], sq[k], busy[k], bs};
  endfunction

  task automatic check(input string name, input int k, input logic [10:0] ef,
                       input logic [1:0] eb);
    logic [12:0] got;
    got = obs(k);
    checks++;
    if (got !== {ef, eb}) begin
      failures++;
      $display("FAIL %s dut=%0d got=%b expected=%b", name, k, got, {ef, eb});
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] op, input logic f,
                       input logic [4:0] s);
    in_valid = v; opcode = op; fl = f;
    {wr_in, lrn_in, lr0_in, ern_in, isp_in} = s;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string      name;
    logic       v;
    logic [7:0] op;
    logic       f;
    logic [4:0] s;      // {wr_in, lrn_in, lr0_in, ern_in, isp_in}
    logic [10:0] exp;   // ov_wr_{lrn,lr0,ern}_lsp_{dsp,isp,lop}_sq_busy
  } vec_t;

  vec_t vt[11];

  initial begin
    vt[0]  = '{"ccd_fail",   1'b1, 8'b0011_0001, 1'b0, 5'b10000, 11'b1_0_000_0_000_1_0};
    vt[1]  = '{"ccd_pass",   1'b1, 8'b0011_0001, 1'b1, 5'b10000, 11'b1_1_000_0_100_0_0};
    vt[2]  = '{"out_lop",    1'b1, 8'b1111_1011, 1'b0, 5'b00000, 11'b1_0_000_0_001_0_0};
    vt[3]  = '{"out_novld",  1'b0, 8'b1111_1011, 1'b1, 5'b11111, 11'b0_0_000_0_000_0_0};
    vt[4]  = '{"lsp",        1'b1, 8'b0001_0000, 1'b0, 5'b01110, 11'b1_0_111_1_000_0_0};
    vt[5]  = '{"psh",        1'b1, 8'b0110_1010, 1'b0, 5'b10001, 11'b1_1_000_0_110_0_0};
    vt[6]  = '{"jcd_fail",   1'b1, 8'b0000_1100, 1'b0, 5'b11001, 11'b1_0_000_0_100_1_0};
    vt[7]  = '{"jca_pass",   1'b1, 8'b0010_1000, 1'b1, 5'b11001, 11'b1_1_100_0_010_0_0};
    vt[8]  = '{"nop",        1'b1, 8'b0000_0000, 1'b0, 5'b00010, 11'b1_0_001_0_000_0_0};
    vt[9]  = '{"rtc_fail1",  1'b1, 8'b0100_1010, 1'b0, 5'b00001, 11'b1_0_000_0_100_1_0};
    vt[10] = '{"cud_1beat",  1'b1, 8'b0000_0101, 1'b0, 5'b10000, 11'b1_1_000_0_100_0_0};

    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(1'b1, 8'b0000_0110, 1'b1, 5'b11111);
    tick(); tick();
    for (int k = 0; k < 3; k++) check("reset", k, '0, 2'd0);
    rst = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 5'b0);
    tick();

    // single-beat decode/qualification on the 1-beat instance
    for (int i = 0; i < 11; i++) begin
      drive(vt[i].v, vt[i].op, vt[i].f, vt[i].s);
      tick();
      check(vt[i].name, 0, vt[i].exp, 2'd0);
    end
    drive(1'b0, 8'h00, 1'b0, 5'b0);
    tick();
    check("idle_after", 0, '0, 2'd0);

    // two-beat CUA
    drive(1'b1, 8'b0000_0110, 1'b0, 5'b10000);
    tick();
    check("cua_beat0", 1, 11'b1_1_000_0_100_0_1, 2'd0);
    drive(1'b0, 8'h00, 1'b0, 5'b0);
    tick();
    check("cua_beat1", 1, 11'b1_1_000_0_100_0_0, 2'd1);
    tick();
    check("cua_done", 1, '0, 2'd0);

    // failing RTC on two-beat instance: single squashed beat
    drive(1'b1, 8'b0100_1010, 1'b0, 5'b00001);
    tick();
    check("rtc_squash", 1, 11'b1_0_000_0_100_1_0, 2'd0);
    drive(1'b0, 8'h00, 1'b0, 5'b0);
    tick();
    check("rtc_nobusy", 1, '0, 2'd0);

    // three-beat CUD with stall held on the second beat
    drive(1'b1, 8'b0000_0101, 1'b0, 5'b10000);
    tick();
    check("cud3_b0", 2, 11'b1_1_000_0_100_0_1, 2'd0);
    drive(1'b0, 8'h00, 1'b0, 5'b0);
    tick();
    check("cud3_b1", 2, 11'b1_1_000_0_100_0_1, 2'd1);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("cud3_stall", 2, 11'b1_1_000_0_100_0_1, 2'd1);
    end
    stall = 1'b0;
    tick();
    check("cud3_b2", 2, 11'b1_1_000_0_100_0_0, 2'd2);
    tick();
    check("cud3_done", 2, '0, 2'd0);

    // flush (with stall) aborts a call in its first beat
    drive(1'b1, 8'b0000_0110, 1'b0, 5'b10000);
    tick();
    check("fl_beat0", 1, 11'b1_1_000_0_100_0_1, 2'd0);
    drive(1'b0, 8'h00, 1'b0, 5'b0);
    flush = 1'b1; stall = 1'b1;
    tick();
    check("flush_abort", 1, '0, 2'd0);
    flush = 1'b0; stall = 1'b0;
    tick();
    check("flush_idle", 1, '0, 2'd0);

    // reset mid-sequence
    drive(1'b1, 8'b0000_0110, 1'b0, 5'b10000);
    tick();
    check("rs_beat0", 1, 11'b1_1_000_0_100_0_1, 2'd0);
    drive(1'b0, 8'h00, 1'b0, 5'b0);
    rst = 1'b1;
    tick();
    check("rst_abort", 1, '0, 2'd0);
    rst = 1'b0;
    tick();
    check("rst_idle", 1, '0, 2'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
